// File: rtl/tail_light_decoder.sv
// Receive-side monitor for the 6-bit tail-light bus: tracks left/right sweeps and hazard, flags protocol violations.
// Event counters are built only when TAIL_LIGHT_DECODER_CNT_EN is defined; otherwise they read 0.
module tail_light_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       i_light,
  input  logic             i_clr_err,
  output logic             o_left_active,
  output logic             o_right_active,
  output logic             o_haz_active,
  output logic             o_sweep_done,
  output logic             o_sweep_dir,
  output logic             o_err,
  output logic             o_err_flag,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_left_cnt,
  output logic [CNT_W-1:0] o_right_cnt,
  output logic [CNT_W-1:0] o_haz_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEFT1, S_LEFT2, S_LEFT3, S_RIGHT1, S_RIGHT2, S_RIGHT3, S_HAZ, S_SYNC
  } state_t;

  localparam logic [5:0] C_OFF = 6'b000000;
  localparam logic [5:0] C_L1  = 6'b001000;
  localparam logic [5:0] C_L2  = 6'b011000;
  localparam logic [5:0] C_L3  = 6'b111000;
  localparam logic [5:0] C_R1  = 6'b000100;
  localparam logic [5:0] C_R2  = 6'b000110;
  localparam logic [5:0] C_R3  = 6'b000111;
  localparam logic [5:0] C_HAZ = 6'b111111;

  localparam logic [1:0] E_CODE  = 2'b01;
  localparam logic [1:0] E_TRANS = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic       w_legal;
  logic       w_err;
  logic [1:0] w_err_code;
  logic       w_enter_l3;
  logic       w_enter_r3;
  logic       w_enter_haz;

  logic       r_sweep_done;
  logic       r_sweep_dir;
  logic       r_err;
  logic       r_err_flag;
  logic [1:0] r_err_code;

  always_comb begin
    w_legal = 1'b0;
    case (i_light)
      C_OFF, C_L1, C_L2, C_L3, C_R1, C_R2, C_R3, C_HAZ: w_legal = 1'b1;
      default:                                          w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_err_code = 2'b00;
    if (r_state == S_SYNC) begin
      // Resynchronising: everything but OFF is ignored so one incident reports one error.
      if (i_light == C_OFF) w_next = S_IDLE;
    end else if (!w_legal) begin
      w_next     = S_SYNC;
      w_err      = 1'b1;
      w_err_code = E_CODE;
    end else begin
      w_next     = S_SYNC;
      w_err      = 1'b1;
      w_err_code = E_TRANS;
      case (r_state)
        S_IDLE: begin
          if      (i_light == C_OFF) w_next = S_IDLE;
          else if (i_light == C_L1)  w_next = S_LEFT1;
          else if (i_light == C_R1)  w_next = S_RIGHT1;
          else if (i_light == C_HAZ) w_next = S_HAZ;
        end
        S_LEFT1: begin
          if      (i_light == C_L2)  w_next = S_LEFT2;
          else if (i_light == C_HAZ) w_next = S_HAZ;
        end
        S_LEFT2: begin
          if      (i_light == C_L3)  w_next = S_LEFT3;
          else if (i_light == C_HAZ) w_next = S_HAZ;
        end
        S_RIGHT1: begin
          if      (i_light == C_R2)  w_next = S_RIGHT2;
          else if (i_light == C_HAZ) w_next = S_HAZ;
        end
        S_RIGHT2: begin
          if      (i_light == C_R3)  w_next = S_RIGHT3;
          else if (i_light == C_HAZ) w_next = S_HAZ;
        end
        S_LEFT3, S_RIGHT3, S_HAZ: begin
          if (i_light == C_OFF) w_next = S_IDLE;
        end
        default: w_next = S_SYNC;
      endcase
      if (w_next != S_SYNC) begin
        w_err      = 1'b0;
        w_err_code = 2'b00;
      end
    end
  end

  assign w_enter_l3  = (r_state == S_LEFT2)  && (w_next == S_LEFT3);
  assign w_enter_r3  = (r_state == S_RIGHT2) && (w_next == S_RIGHT3);
  assign w_enter_haz = (r_state == S_IDLE)   && (w_next == S_HAZ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sweep_done <= 1'b0;
      r_sweep_dir  <= 1'b0;
      r_err        <= 1'b0;
      r_err_flag   <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_state      <= w_next;
      r_sweep_done <= w_enter_l3 | w_enter_r3;
      r_err        <= w_err;
      if (w_enter_l3) r_sweep_dir <= 1'b0;
      if (w_enter_r3) r_sweep_dir <= 1'b1;
      if (w_err) r_err_code <= w_err_code;
      // A new error beats a simultaneous clear.
      if (w_err)          r_err_flag <= 1'b1;
      else if (i_clr_err) r_err_flag <= 1'b0;
    end
  end

  assign o_left_active  = (r_state == S_LEFT1)  || (r_state == S_LEFT2)  || (r_state == S_LEFT3);
  assign o_right_active = (r_state == S_RIGHT1) || (r_state == S_RIGHT2) || (r_state == S_RIGHT3);
  assign o_haz_active   = (r_state == S_HAZ);
  assign o_sweep_done   = r_sweep_done;
  assign o_sweep_dir    = r_sweep_dir;
  assign o_err          = r_err;
  assign o_err_flag     = r_err_flag;
  assign o_err_code     = r_err_code;

`ifdef TAIL_LIGHT_DECODER_CNT_EN
  logic [CNT_W-1:0] r_left_cnt;
  logic [CNT_W-1:0] r_right_cnt;
  logic [CNT_W-1:0] r_haz_cnt;

  // Counters saturate at all-ones and survive clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_cnt  <= '0;
      r_right_cnt <= '0;
      r_haz_cnt   <= '0;
    end else begin
      if (w_enter_l3  && (r_left_cnt  != '1)) r_left_cnt  <= r_left_cnt  + 1'b1;
      if (w_enter_r3  && (r_right_cnt != '1)) r_right_cnt <= r_right_cnt + 1'b1;
      if (w_enter_haz && (r_haz_cnt   != '1)) r_haz_cnt   <= r_haz_cnt   + 1'b1;
    end
  end

  assign o_left_cnt  = r_left_cnt;
  assign o_right_cnt = r_right_cnt;
  assign o_haz_cnt   = r_haz_cnt;
`else
  assign o_left_cnt  = '0;
  assign o_right_cnt = '0;
  assign o_haz_cnt   = '0;
`endif

endmodule

// File: tb/tb_tail_light_decoder.sv
// Scoreboarded bench for tail_light_decoder: directed vectors push hand-computed expectations, a monitor compares.
module tb_tail_light_decoder;

  localparam int CNT_W = 2;
`ifdef TAIL_LIGHT_DECODER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [5:0] OFF = 6'b000000;
  localparam logic [5:0] L1  = 6'b001000;
  localparam logic [5:0] L2  = 6'b011000;
  localparam logic [5:0] L3  = 6'b111000;
  localparam logic [5:0] R1  = 6'b000100;
  localparam logic [5:0] R2  = 6'b000110;
  localparam logic [5:0] R3  = 6'b000111;
  localparam logic [5:0] HZ  = 6'b111111;
  localparam logic [5:0] BAD = 6'b010101;

  logic             clk;
  logic             reset;
  logic [5:0]       i_light;
  logic             i_clr_err;
  logic             o_left_active;
  logic             o_right_active;
  logic             o_haz_active;
  logic             o_sweep_done;
  logic             o_sweep_dir;
  logic             o_err;
  logic             o_err_flag;
  logic [1:0]       o_err_code;
  logic [CNT_W-1:0] o_left_cnt;
  logic [CNT_W-1:0] o_right_cnt;
  logic [CNT_W-1:0] o_haz_cnt;

  tail_light_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_light(i_light), .i_clr_err(i_clr_err),
    .o_left_active(o_left_active), .o_right_active(o_right_active),
    .o_haz_active(o_haz_active), .o_sweep_done(o_sweep_done),
    .o_sweep_dir(o_sweep_dir), .o_err(o_err), .o_err_flag(o_err_flag),
    .o_err_code(o_err_code), .o_left_cnt(o_left_cnt),
    .o_right_cnt(o_right_cnt), .o_haz_cnt(o_haz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {left, right, haz, sweep_done, sweep_dir, err, err_flag, err_code[1:0]}
  typedef struct {
    int         id;
    logic [8:0] flags;
    logic [5:0] cnts;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;

  function automatic logic [8:0] act_flags();
    return {o_left_active, o_right_active, o_haz_active, o_sweep_done,
            o_sweep_dir, o_err, o_err_flag, o_err_code};
  endfunction

  function automatic logic [5:0] exp_cnts(input int lc, input int rc, input int hc);
    logic [5:0] v;
    v = {lc[1:0], rc[1:0], hc[1:0]};
    return CNT_ON ? v : 6'd0;
  endfunction

  task automatic check(input string name, input int id, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, id, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] code, input logic clr, input logic [8:0] f,
                      input int lc, input int rc, input int hc);
    exp_t e;
    @(negedge clk);
    i_light   = code;
    i_clr_err = clr;
    vec_id++;
    e.id    = vec_id;
    e.flags = f;
    e.cnts  = exp_cnts(lc, rc, hc);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) check("done_err_coincide", vec_id, {8'd0, o_sweep_done & o_err}, 9'd0);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("flags", e.id, act_flags(), e.flags);
        check("counters", e.id, {3'd0, o_left_cnt, o_right_cnt, o_haz_cnt}, {3'd0, e.cnts});
      end
    end
  end

  initial begin : stim
    reset     = 1'b1;
    i_light   = OFF;
    i_clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 0, act_flags(), 9'd0);
    check("reset_cnts", 0, {3'd0, o_left_cnt, o_right_cnt, o_haz_cnt}, 9'd0);
    @(negedge clk);
    reset = 1'b0;

    // left sweep
    step(OFF, 0, 9'b000_0_0_0_0_00, 0, 0, 0);
    step(L1,  0, 9'b100_0_0_0_0_00, 0, 0, 0);
    step(L2,  0, 9'b100_0_0_0_0_00, 0, 0, 0);
    step(L3,  0, 9'b100_1_0_0_0_00, 1, 0, 0);
    step(OFF, 0, 9'b000_0_0_0_0_00, 1, 0, 0);
    // right sweep then hazard blink x3
    step(R1,  0, 9'b010_0_0_0_0_00, 1, 0, 0);
    step(R2,  0, 9'b010_0_0_0_0_00, 1, 0, 0);
    step(R3,  0, 9'b010_1_1_0_0_00, 1, 1, 0);
    step(OFF, 0, 9'b000_0_1_0_0_00, 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step(HZ,  0, 9'b001_0_1_0_0_00, 1, 1, i);
      step(OFF, 0, 9'b000_0_1_0_0_00, 1, 1, i);
    end
    // illegal code, then ignored samples in SYNC
    step(L1,  0, 9'b100_0_1_0_0_00, 1, 1, 3);
    step(BAD, 0, 9'b000_0_1_1_1_01, 1, 1, 3);
    step(L2,  0, 9'b000_0_1_0_1_01, 1, 1, 3);
    step(L2,  0, 9'b000_0_1_0_1_01, 1, 1, 3);
    step(OFF, 0, 9'b000_0_1_0_1_01, 1, 1, 3);
    // illegal transition, clear colliding with a new error, then clear alone
    step(L1,  0, 9'b100_0_1_0_1_01, 1, 1, 3);
    step(L3,  0, 9'b000_0_1_1_1_10, 1, 1, 3);
    step(OFF, 0, 9'b000_0_1_0_1_10, 1, 1, 3);
    step(R1,  0, 9'b010_0_1_0_1_10, 1, 1, 3);
    step(R3,  1, 9'b000_0_1_1_1_10, 1, 1, 3);
    step(OFF, 0, 9'b000_0_1_0_1_10, 1, 1, 3);
    step(OFF, 1, 9'b000_0_1_0_0_10, 1, 1, 3);
    // reset during LEFT2
    step(L1,  0, 9'b100_0_1_0_0_10, 1, 1, 3);
    step(L2,  0, 9'b100_0_1_0_0_10, 1, 1, 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_flags", vec_id, act_flags(), 9'd0);
    check("async_reset_cnts", vec_id, {3'd0, o_left_cnt, o_right_cnt, o_haz_cnt}, 9'd0);
    @(negedge clk);
    i_light = OFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(L3,  0, 9'b000_0_0_1_1_10, 0, 0, 0);
    step(OFF, 0, 9'b000_0_0_0_1_10, 0, 0, 0);
    // hazard entered from LEFT1 is legal but not an IDLE->HAZ event
    step(L1,  0, 9'b100_0_0_0_1_10, 0, 0, 0);
    step(HZ,  0, 9'b001_0_0_0_1_10, 0, 0, 0);
    step(OFF, 0, 9'b000_0_0_0_1_10, 0, 0, 0);
    // five left sweeps saturate a 2-bit counter
    for (int n = 1; n <= 5; n++) begin
      step(L1,  0, 9'b100_0_0_0_1_10, (n - 1 > 3) ? 3 : n - 1, 0, 0);
      step(L2,  0, 9'b100_0_0_0_1_10, (n - 1 > 3) ? 3 : n - 1, 0, 0);
      step(L3,  0, 9'b100_1_0_0_1_10, (n > 3) ? 3 : n, 0, 0);
      step(OFF, 0, 9'b000_0_0_0_1_10, (n > 3) ? 3 : n, 0, 0);
    end

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", vec_id, q.size() > 0 ? 9'd1 : 9'd0, 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
